// File: rtl/control_sucio_flush_mem_data_if.sv
// Access, control, status and flush-drain signals of the data-RAM dirty-line tracker.
// master = RAM access / debug-unit side, slave = tracker.
interface control_sucio_flush_mem_data_if #(
  parameter int RAM_DEPTH  = 1024,
  parameter int LINE_WORDS = 4
);
  localparam int NUM_LINES = RAM_DEPTH / LINE_WORDS;
  localparam int NB_ADDR   = $clog2(RAM_DEPTH);
  localparam int NB_LINE   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int NB_CNT    = $clog2(NUM_LINES + 1);

  logic [NB_ADDR-1:0] i_addr;
  logic               i_ena;
  logic               i_wea;
  logic               i_clear_all;
  logic               i_flush_start;
  logic               i_flush_ready;
  logic               o_bit_sucio;
  logic               o_any_dirty;
  logic [NB_CNT-1:0]  o_dirty_count;
  logic               o_flush_valid;
  logic [NB_LINE-1:0] o_flush_line;
  logic               o_flush_busy;
  logic               o_flush_done;

  modport master (
    output i_addr, i_ena, i_wea, i_clear_all, i_flush_start, i_flush_ready,
    input  o_bit_sucio, o_any_dirty, o_dirty_count,
           o_flush_valid, o_flush_line, o_flush_busy, o_flush_done
  );

  modport slave (
    input  i_addr, i_ena, i_wea, i_clear_all, i_flush_start, i_flush_ready,
    output o_bit_sucio, o_any_dirty, o_dirty_count,
           o_flush_valid, o_flush_line, o_flush_busy, o_flush_done
  );
endinterface

// File: rtl/control_sucio_flush_mem_data.sv
// Line-granular dirty-bit tracker for the data RAM with a one-pass write-back scan engine
// that offers each dirty line over a valid/ready port and keeps a live dirty-line count.
module control_sucio_flush_mem_data #(
  parameter int RAM_DEPTH  = 1024,
  parameter int LINE_WORDS = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  control_sucio_flush_mem_data_if.slave bus
);
  localparam int NUM_LINES = RAM_DEPTH / LINE_WORDS;
  localparam int NB_LINE   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int NB_CNT    = $clog2(NUM_LINES + 1);
  localparam int LW_BITS   = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_OFFER = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state, state_nx;
  logic [NB_LINE-1:0]   ptr, ptr_nx;
  logic [NUM_LINES-1:0] dirty, dirty_nx;
  logic [NB_CNT-1:0]    cnt, cnt_nx;

  logic [NB_LINE-1:0]   acc_line;
  logic                 wr;
  logic                 last;
  logic                 handshake;
  logic                 set_new;
  logic                 clr_cnt;

  assign acc_line = NB_LINE'(bus.i_addr >> LW_BITS);
  assign wr       = bus.i_ena & bus.i_wea;
  assign last     = (ptr == NB_LINE'(NUM_LINES - 1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= S_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    handshake = 1'b0;
    if (bus.i_clear_all) begin
      state_nx = S_IDLE;
      ptr_nx   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.i_flush_start) begin
            state_nx = S_SCAN;
            ptr_nx   = '0;
          end
        end
        S_SCAN: begin
          if (dirty[ptr])  state_nx = S_OFFER;
          else if (last)   state_nx = S_DONE;
          else             ptr_nx   = ptr + NB_LINE'(1);
        end
        S_OFFER: begin
          if (bus.i_flush_ready) begin
            handshake = 1'b1;
            if (last) begin
              state_nx = S_DONE;
            end else begin
              state_nx = S_SCAN;
              ptr_nx   = ptr + NB_LINE'(1);
            end
          end
        end
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // The write is applied after the drain clear, so a write landing on the line
  // being handed off keeps it dirty: its data is newer than what was drained.
  always_comb begin
    dirty_nx = dirty;
    if (handshake) dirty_nx[ptr] = 1'b0;
    if (wr)        dirty_nx[acc_line] = 1'b1;
  end

  assign set_new = wr & ~dirty[acc_line];
  assign clr_cnt = handshake & ~(wr && (acc_line == ptr));

  always_comb begin
    cnt_nx = cnt;
    unique case ({set_new, clr_cnt})
      2'b10:   cnt_nx = cnt + NB_CNT'(1);
      2'b01:   cnt_nx = cnt - NB_CNT'(1);
      default: cnt_nx = cnt;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      dirty <= '0;
      cnt   <= '0;
    end else if (bus.i_clear_all) begin
      dirty <= '0;
      cnt   <= '0;
    end else begin
      dirty <= dirty_nx;
      cnt   <= cnt_nx;
    end
  end

  assign bus.o_bit_sucio   = dirty[acc_line];
  assign bus.o_any_dirty   = (cnt != '0);
  assign bus.o_dirty_count = cnt;
  assign bus.o_flush_valid = (state == S_OFFER);
  assign bus.o_flush_line  = ptr;
  assign bus.o_flush_busy  = (state != S_IDLE);
  assign bus.o_flush_done  = (state == S_DONE);
endmodule

// File: tb/tb_control_sucio_flush_mem_data.sv
// Directed bench for the dirty-line tracker: 4-line instance plus a 16-line instance for pass latency.
module tb_control_sucio_flush_mem_data;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  control_sucio_flush_mem_data_if #(.RAM_DEPTH(16), .LINE_WORDS(4)) bus ();
  control_sucio_flush_mem_data_if #(.RAM_DEPTH(16), .LINE_WORDS(1)) bus1 ();

  control_sucio_flush_mem_data #(.RAM_DEPTH(16), .LINE_WORDS(4)) u_dut (
    .i_clk(clk), .i_reset(rst_n), .bus(bus)
  );
  control_sucio_flush_mem_data #(.RAM_DEPTH(16), .LINE_WORDS(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst_n), .bus(bus1)
  );

  int tests = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] addr;
    logic       ena;
    logic       wea;
    logic       clr;
    logic       exp_bit;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_write(input logic [3:0] a);
    bus.i_addr = a;
    bus.i_ena  = 1'b1;
    bus.i_wea  = 1'b1;
    step();
    bus.i_ena  = 1'b0;
    bus.i_wea  = 1'b0;
  endtask

  task automatic do_clear();
    bus.i_clear_all = 1'b1;
    step();
    bus.i_clear_all = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0, d1;
    logic any_valid;

    vecs[0]  = '{4'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1};
    vecs[1]  = '{4'd6,  1'b1, 1'b1, 1'b0, 1'b1, 1};
    vecs[2]  = '{4'd4,  1'b1, 1'b0, 1'b0, 1'b1, 1};
    vecs[3]  = '{4'd7,  1'b1, 1'b0, 1'b0, 1'b1, 1};
    vecs[4]  = '{4'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{4'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[6]  = '{4'd13, 1'b1, 1'b1, 1'b0, 1'b0, 2};
    vecs[7]  = '{4'd12, 1'b0, 1'b1, 1'b0, 1'b1, 2};
    vecs[8]  = '{4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 2};
    vecs[9]  = '{4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2};
    vecs[10] = '{4'd2,  1'b1, 1'b1, 1'b1, 1'b0, 0};
    vecs[11] = '{4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[12] = '{4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 1};

    bus.i_addr = '0; bus.i_ena = 1'b0; bus.i_wea = 1'b0;
    bus.i_clear_all = 1'b0; bus.i_flush_start = 1'b0; bus.i_flush_ready = 1'b0;
    bus1.i_addr = '0; bus1.i_ena = 1'b0; bus1.i_wea = 1'b0;
    bus1.i_clear_all = 1'b0; bus1.i_flush_start = 1'b0; bus1.i_flush_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("reset count", bus.o_dirty_count, 0);
    chk("reset any", bus.o_any_dirty, 0);
    chk("reset valid", bus.o_flush_valid, 0);
    chk("reset busy", bus.o_flush_busy, 0);
    chk("reset done", bus.o_flush_done, 0);
    chk("reset line", bus.o_flush_line, 0);
    rst_n = 1'b1;
    step();

    // Write/read pattern table
    for (int i = 0; i < 13; i++) begin
      bus.i_addr      = vecs[i].addr;
      bus.i_ena       = vecs[i].ena;
      bus.i_wea       = vecs[i].wea;
      bus.i_clear_all = vecs[i].clr;
      #1;
      chk($sformatf("vec%0d bit", i), bus.o_bit_sucio, vecs[i].exp_bit);
      step();
      chk($sformatf("vec%0d count", i), bus.o_dirty_count, vecs[i].exp_cnt);
      chk($sformatf("vec%0d any", i), bus.o_any_dirty, (vecs[i].exp_cnt != 0));
    end
    bus.i_ena = 1'b0; bus.i_wea = 1'b0; bus.i_clear_all = 1'b0;

    // Reset asserted while a line is on offer
    do_clear();
    do_write(4'd0);
    bus.i_flush_start = 1'b1;
    step();
    bus.i_flush_start = 1'b0;
    step();
    chk("t1 offer valid", bus.o_flush_valid, 1);
    chk("t1 offer line", bus.o_flush_line, 0);
    bus.i_addr = 4'd0;
    rst_n = 1'b0;
    #1;
    chk("t1 rst valid", bus.o_flush_valid, 0);
    chk("t1 rst busy", bus.o_flush_busy, 0);
    chk("t1 rst done", bus.o_flush_done, 0);
    chk("t1 rst count", bus.o_dirty_count, 0);
    chk("t1 rst any", bus.o_any_dirty, 0);
    chk("t1 rst bit", bus.o_bit_sucio, 0);
    chk("t1 rst line", bus.o_flush_line, 0);
    step();
    rst_n = 1'b1;
    step();

    // Lines 1 and 3 dirty, ready tied high: done seven cycles after start
    do_write(4'd4);
    do_write(4'd12);
    chk("t3 count pre", bus.o_dirty_count, 2);
    bus.i_flush_ready = 1'b1;
    bus.i_flush_start = 1'b1;
    step();
    bus.i_flush_start = 1'b0;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      chk($sformatf("t3 c%0d valid", cyc), bus.o_flush_valid, (cyc == 3 || cyc == 6));
      if (cyc == 3) chk("t3 line1", bus.o_flush_line, 1);
      if (cyc == 6) chk("t3 line3", bus.o_flush_line, 3);
      chk($sformatf("t3 c%0d done", cyc), bus.o_flush_done, (cyc == 7));
      if (cyc < 7) step();
    end
    chk("t3 count post", bus.o_dirty_count, 0);
    step();
    chk("t3 idle", bus.o_flush_busy, 0);
    bus.i_flush_ready = 1'b0;

    // Line 2 held on offer by a stalled consumer, then write to it during handshake
    do_write(4'd8);
    bus.i_flush_start = 1'b1;
    step();
    bus.i_flush_start = 1'b0;
    n = 0;
    while (!bus.o_flush_valid && n < 10) begin
      step();
      n++;
    end
    chk("t4 reach offer", bus.o_flush_valid, 1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4 stall%0d valid", k), bus.o_flush_valid, 1);
      chk($sformatf("t4 stall%0d line", k), bus.o_flush_line, 2);
      step();
    end
    bus.i_flush_ready = 1'b1;
    bus.i_addr = 4'd9;
    bus.i_ena = 1'b1;
    bus.i_wea = 1'b1;
    step();
    bus.i_flush_ready = 1'b0;
    bus.i_ena = 1'b0;
    bus.i_wea = 1'b0;
    #1;
    chk("t4 bit kept", bus.o_bit_sucio, 1);
    chk("t4 count kept", bus.o_dirty_count, 1);
    n = 0;
    while (!bus.o_flush_done && n < 10) begin
      step();
      n++;
    end
    chk("t4 done seen", bus.o_flush_done, 1);
    chk("t4 count end", bus.o_dirty_count, 1);
    step();

    // Clear while offering line 0; start during busy is ignored
    do_clear();
    do_write(4'd1);
    bus.i_flush_start = 1'b1;
    step();
    bus.i_flush_start = 1'b0;
    step();
    chk("t5 offer valid", bus.o_flush_valid, 1);
    chk("t5 offer line", bus.o_flush_line, 0);
    bus.i_flush_start = 1'b1;
    step();
    bus.i_flush_start = 1'b0;
    chk("t5 start ignored valid", bus.o_flush_valid, 1);
    chk("t5 start ignored line", bus.o_flush_line, 0);
    bus.i_clear_all = 1'b1;
    step();
    bus.i_clear_all = 1'b0;
    chk("t5 clr valid", bus.o_flush_valid, 0);
    chk("t5 clr busy", bus.o_flush_busy, 0);
    chk("t5 clr count", bus.o_dirty_count, 0);
    any_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (bus.o_flush_done || bus.o_flush_busy) any_valid = 1'b1;
      step();
    end
    chk("t5 no done after clr", any_valid, 0);

    // Empty passes on both geometries
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    bus.i_flush_ready = 1'b1;
    bus1.i_flush_ready = 1'b1;
    bus.i_flush_start = 1'b1;
    bus1.i_flush_start = 1'b1;
    step();
    bus.i_flush_start = 1'b0;
    bus1.i_flush_start = 1'b0;
    d0 = -1;
    d1 = -1;
    any_valid = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (bus.o_flush_done && d0 < 0) d0 = cyc;
      if (bus1.o_flush_done && d1 < 0) d1 = cyc;
      if (bus.o_flush_valid || bus1.o_flush_valid) any_valid = 1'b1;
      step();
    end
    chk("t6 done 4 lines", d0, 5);
    chk("t6 done 16 lines", d1, 17);
    chk("t6 no valid", any_valid, 0);
    chk("t6 idle", bus.o_flush_busy | bus1.o_flush_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
